spi_coeff_loader: RTL

SPI_COEFF_LOADER -- requirements
Module: spi_coeff_loader

---
 rtl/spi_coeff_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_coeff_loader.sv
// SPI-fed FIR coefficient loader: frames write a shadow bank, committed to coeffs on cs rise.
// Inputs synchronized (2 flops); coeffUpdate follows the cs rise by 2 sync + 1 detect + 1 commit cycles.
module spi_coeff_loader #(
  parameter int NTaps     = 13,
  parameter int DataWidth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spiClk,
  input  logic                         mosi,
  input  logic                         cs,
  output logic [NTaps*DataWidth-1:0]   coeffs,
  output logic                         coeffUpdate,
  output logic                         busy
);

  localparam int         SrW      = (DataWidth > 8) ? DataWidth : 8;
  localparam logic [8:0] NTapsW   = 9'(NTaps);
  localparam logic [7:0] LastData = 8'(DataWidth - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  logic [1:0]                 r_cs_sync, r_sclk_sync, r_mosi_sync;
  logic                       r_cs_prev, r_sclk_prev;
  state_t                     r_state;
  logic [7:0]                 r_bit_cnt;
  logic [SrW-1:0]             r_shift;
  logic [7:0]                 r_ptr;
  logic                       r_wr_flag;
  logic                       r_commit;
  logic                       r_busy;
  logic                       r_upd;
  logic [NTaps*DataWidth-1:0] r_shadow;
  logic [NTaps*DataWidth-1:0] r_coeffs;

  logic                 w_cs_fall, w_cs_rise, w_sclk_rise;
  logic [SrW-1:0]       w_shift_next;
  logic [DataWidth-1:0] w_word;

  // Synchronizers reset to bus-idle levels so release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_sync   <= 2'b11;
      r_sclk_sync <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_cs_prev   <= 1'b1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[0], cs};
      r_sclk_sync <= {r_sclk_sync[0], spiClk};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_cs_prev   <= r_cs_sync[1];
      r_sclk_prev <= r_sclk_sync[1];
    end
  end

  assign w_cs_fall    = r_cs_prev & ~r_cs_sync[1];
  assign w_cs_rise    = ~r_cs_prev & r_cs_sync[1];
  assign w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_prev;
  assign w_shift_next = {r_shift[SrW-2:0], r_mosi_sync[1]};
  assign w_word       = w_shift_next[DataWidth-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_wr_flag <= 1'b0;
      r_commit  <= 1'b0;
      r_busy    <= 1'b0;
      r_upd     <= 1'b0;
      r_shadow  <= '0;
      r_coeffs  <= '0;
    end else begin
      r_upd <= 1'b0;
      if (r_commit) begin
        r_coeffs <= r_shadow;
        r_upd    <= 1'b1;
        r_commit <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state   <= ADDR;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_wr_flag <= 1'b0;
          end
        end
        ADDR, DATA: begin
          // cs rise has priority over a coincident spiClk edge; partial words die here.
          if (w_cs_rise) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_commit <= r_wr_flag;
          end else if (w_sclk_rise) begin
            if (r_state == ADDR) begin
              if (r_bit_cnt == 8'd7) begin
                r_ptr     <= w_shift_next[7:0];
                r_state   <= DATA;
                r_bit_cnt <= '0;
                r_shift   <= '0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 8'd1;
                r_shift   <= w_shift_next;
              end
            end else if (r_bit_cnt == LastData) begin
              if ({1'b0, r_ptr} < NTapsW) begin
                r_wr_flag <= 1'b1;
                for (int i = 0; i < NTaps; i++) begin
                  if (r_ptr == 8'(i)) r_shadow[i*DataWidth +: DataWidth] <= w_word;
                end
              end
              r_ptr     <= (r_ptr == 8'hFF) ? 8'hFF : r_ptr + 8'd1;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
              r_shift   <= w_shift_next;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign coeffs      = r_coeffs;
  assign coeffUpdate = r_upd;
  assign busy        = r_busy;

endmodule
